rm_commit_symbolizer: RTL and testbench

// - Producer end of the runtime-monitor symbol interface.
// - Converts CVA6 commit-port events (2 ports) into the 8-bit symbol stream consumed by Automata_* monitors.
// - Tracks load-use dependencies, buffers bursts in a FIFO and drives symbols/run/mon_reset.
// - Sits between the commit stage and the monitor array.

---
 rtl/rm_commit_symbolizer.sv | 192 +++++++++++++++++++
 tb/tb_rm_commit_symbolizer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rm_commit_symbolizer.sv
`default_nettype none
// ============================================================================
// Module   : rm_commit_symbolizer
// Purpose  : Producer end of the runtime-monitor symbol interface. Turns the
//            two CVA6 commit ports into an 8-bit symbol stream for the
//            Automata_* monitors, tracking load-use dependencies, buffering
//            bursts in a small FIFO and sequencing run / mon_reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       core clock
//   reset        in   1       asynchronous, active-high reset
//   enable       in   1       monitoring enabled
//   commit_valid in   2       per-port commit strobe, port 0 is older
//   commit_class in   2x2     {port1, port0}: 00 other, 01 lw, 10 sw, 11 br/jmp
//   commit_rd    in   2x5     {port1, port0} destination register
//   commit_rs1   in   2x5     {port1, port0} source register 1
//   symbols      out  8       symbol to monitors (registered)
//   run          out  1       symbols valid this cycle (registered)
//   mon_reset    out  1       one-cycle monitor reset (registered)
//   overflow     out  1       sticky, a symbol was dropped
//   drop_cnt     out  CNT_W   saturating dropped-symbol count
// ============================================================================
module rm_commit_symbolizer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       commit_valid,
  input  logic [3:0]       commit_class,
  input  logic [9:0]       commit_rd,
  input  logic [9:0]       commit_rs1,
  output logic [7:0]       symbols,
  output logic             run,
  output logic             mon_reset,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] c_DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW:0] c_ONE   = (CW+1)'(1);
  localparam logic [CW:0] c_TWO   = (CW+1)'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MRST   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_seq;
  logic [4:0]       r_ld_rd;
  logic             r_ld_valid;
  logic [7:0]       r_symbols;
  logic             r_run, r_mon_reset, r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_enq;
  logic [1:0]       w_v;
  logic [4:0]       w_rd0, w_rd1, w_rs0, w_rs1;
  logic [1:0]       w_cls0, w_cls1;
  logic             w_ld_v_mid, w_ld_v_fin;
  logic [4:0]       w_ld_rd_mid, w_ld_rd_fin;
  logic [7:0]       w_sym0, w_sym1, w_head;
  logic [1:0]       w_seq1, w_npush, w_ndrop;
  logic             w_pop_q, w_pop, w_acc0, w_acc1;
  logic [CW:0]      w_space;
  logic [CNT_W:0]   w_drop_sum;

  assign w_rd0  = commit_rd[4:0];
  assign w_rd1  = commit_rd[9:5];
  assign w_rs0  = commit_rs1[4:0];
  assign w_rs1  = commit_rs1[9:5];
  assign w_cls0 = commit_class[1:0];
  assign w_cls1 = commit_class[3:2];

  // Commits only matter while the monitor is being reset or streaming.
  assign w_enq = (r_state == S_MRST) || (r_state == S_STREAM);
  assign w_v   = commit_valid & {2{w_enq}};

  // Tracker is walked in program order: port 1 sees a port-0 lw.
  always_comb begin
    w_ld_v_mid  = r_ld_valid;
    w_ld_rd_mid = r_ld_rd;
    if (w_v[0] && (w_cls0 == 2'b01)) begin
      w_ld_v_mid  = (w_rd0 != 5'd0);
      w_ld_rd_mid = w_rd0;
    end
    w_ld_v_fin  = w_ld_v_mid;
    w_ld_rd_fin = w_ld_rd_mid;
    if (w_v[1] && (w_cls1 == 2'b01)) begin
      w_ld_v_fin  = (w_rd1 != 5'd0);
      w_ld_rd_fin = w_rd1;
    end
  end

  // Admission uses the pre-pop occupancy plus the pop that will happen anyway.
  assign w_pop_q = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && (r_count != '0);
  assign w_space = c_DEPTH - {1'b0, r_count} + {{CW{1'b0}}, w_pop_q};
  assign w_acc0  = w_v[0] && (w_space >= c_ONE);
  assign w_acc1  = w_v[1] && (w_space >= (w_acc0 ? c_TWO : c_ONE));
  assign w_npush = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_ndrop = {1'b0, w_v[0] && !w_acc0} + {1'b0, w_v[1] && !w_acc1};

  // A dropped port-0 symbol does not consume a sequence number.
  assign w_seq1 = r_seq + {1'b0, w_acc0};
  assign w_sym0 = {r_seq, w_cls0,
                   r_ld_valid && (w_rs0 == r_ld_rd),
                   r_ld_valid && (w_rd0 == r_ld_rd), w_rd0[1:0]};
  assign w_sym1 = {w_seq1, w_cls1,
                   w_ld_v_mid && (w_rs1 == w_ld_rd_mid),
                   w_ld_v_mid && (w_rd1 == w_ld_rd_mid), w_rd1[1:0]};

  // Empty FIFO in STREAM bypasses the oldest accepted symbol straight out so
  // a commit reaches the monitor on the next cycle.
  assign w_pop  = w_pop_q || ((r_state == S_STREAM) && (w_acc0 || w_acc1));
  assign w_head = (r_count != '0) ? r_mem[r_rd_ptr] : (w_acc0 ? w_sym0 : w_sym1);

  assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_ndrop};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (enable) w_state_nxt = S_MRST;
      S_MRST:   w_state_nxt = S_STREAM;
      S_STREAM: if (!enable) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (enable)                 w_state_nxt = S_STREAM;
        else if (r_count == '0)     w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_acc0) r_mem[r_wr_ptr] <= w_sym0;
    if (w_acc1) r_mem[r_wr_ptr + PW'(w_acc0)] <= w_sym1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_seq       <= 2'd0;
      r_ld_rd     <= 5'd0;
      r_ld_valid  <= 1'b0;
      r_symbols   <= 8'h00;
      r_run       <= 1'b0;
      r_mon_reset <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mon_reset <= (r_state == S_IDLE) && enable;
      r_run       <= w_pop;
      if (w_pop) r_symbols <= w_head;
      r_wr_ptr    <= r_wr_ptr + PW'(w_npush);
      r_rd_ptr    <= r_rd_ptr + PW'(w_pop);
      r_count     <= r_count + CW'(w_npush) - CW'(w_pop);
      r_seq       <= r_seq + w_npush;
      if (r_state == S_IDLE) begin
        r_ld_valid <= 1'b0;
      end else if (w_enq) begin
        r_ld_valid <= w_ld_v_fin;
        r_ld_rd    <= w_ld_rd_fin;
      end
      if (w_ndrop != 2'd0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
      end
    end
  end

  assign symbols   = r_symbols;
  assign run       = r_run;
  assign mon_reset = r_mon_reset;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rm_commit_symbolizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rm_commit_symbolizer
// Purpose  : Self-checking bench for rm_commit_symbolizer: directed commit
//            vectors with hand-computed symbols, plus multi-cycle sequences
//            for start-up, drain, overflow, asynchronous reset and seq wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rm_commit_symbolizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  commit_valid = 2'b00;
  logic [3:0]  commit_class = 4'h0;
  logic [9:0]  commit_rd = 10'h0;
  logic [9:0]  commit_rs1 = 10'h0;
  logic [7:0]  symbols;
  logic        run, mon_reset, overflow;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rm_commit_symbolizer #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .commit_valid(commit_valid), .commit_class(commit_class),
    .commit_rd(commit_rd), .commit_rs1(commit_rs1),
    .symbols(symbols), .run(run), .mon_reset(mon_reset),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [1:0] c0, c1;
    logic [4:0] rd0, rd1, rs0, rs1;
    int         n;
    logic [7:0] e0, e1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] c0, input logic [1:0] c1,
                       input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    commit_valid = v;
    commit_class = {c1, c0};
    commit_rd    = {rd1, rd0};
    commit_rs1   = {rs1, rs0};
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    vec_t       vt[7];
    logic [7:0] wrap_exp[5];
    int         runs;
    int         breaks;
    logic [1:0] prev_seq;
    logic       have_prev;

    // v, c0, c1, rd0, rd1, rs0, rs1, n, e0, e1
    vt[0] = '{2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 5'd0, 5'd0, 1, 8'h11, 8'h00};
    vt[1] = '{2'b11, 2'b01, 2'b00, 5'd5, 5'd6, 5'd0, 5'd5, 2, 8'h55, 8'h8A};
    vt[2] = '{2'b01, 2'b10, 2'b00, 5'd3, 5'd0, 5'd5, 5'd0, 1, 8'hEB, 8'h00};
    vt[3] = '{2'b11, 2'b01, 2'b11, 5'd0, 5'd5, 5'd2, 5'd5, 2, 8'h10, 8'h71};
    vt[4] = '{2'b11, 2'b01, 2'b01, 5'd7, 5'd7, 5'd0, 5'd7, 2, 8'h93, 8'hDF};
    vt[5] = '{2'b10, 2'b00, 2'b00, 5'd0, 5'd7, 5'd0, 5'd1, 1, 8'h07, 8'h00};
    vt[6] = '{2'b01, 2'b11, 2'b00, 5'd0, 5'd0, 5'd7, 5'd0, 1, 8'h78, 8'h00};
    wrap_exp = '{8'h80, 8'hC0, 8'h00, 8'h40, 8'h80};

    // Reset state
    step();
    step();
    chk("rst_symbols", {24'h0, symbols}, 32'h0);
    chk("rst_run", {31'h0, run}, 32'h0);
    chk("rst_mon_reset", {31'h0, mon_reset}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_drop_cnt", {16'h0, drop_cnt}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Start-up: enable at cycle 0, mon_reset at cycle 1 only
    enable = 1'b1;
    step();
    chk("mrst_cycle1", {31'h0, mon_reset}, 32'h1);
    chk("mrst_no_run", {31'h0, run}, 32'h0);
    step();
    chk("mrst_cycle2_low", {31'h0, mon_reset}, 32'h0);

    // Directed vectors: each applied for one cycle with the FIFO empty
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].v, vt[i].c0, vt[i].c1, vt[i].rd0, vt[i].rd1, vt[i].rs0, vt[i].rs1);
      step();
      idle();
      chk($sformatf("vec%0d_run0", i), {31'h0, run}, 32'h1);
      chk($sformatf("vec%0d_sym0", i), {24'h0, symbols}, {24'h0, vt[i].e0});
      step();
      if (vt[i].n == 2) begin
        chk($sformatf("vec%0d_run1", i), {31'h0, run}, 32'h1);
        chk($sformatf("vec%0d_sym1", i), {24'h0, symbols}, {24'h0, vt[i].e1});
      end else begin
        chk($sformatf("vec%0d_run1", i), {31'h0, run}, 32'h0);
        chk($sformatf("vec%0d_hold", i), {24'h0, symbols}, {24'h0, vt[i].e0});
      end
    end

    // Drain: build 5 queued entries, drop enable, commit during DRAIN
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
      step();
    end
    idle();
    enable = 1'b0;
    runs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (run) runs++;
      if (i < 3) drive(2'b11, 2'b00, 2'b00, 5'd1, 5'd1, 5'd0, 5'd0);
      else idle();
    end
    chk("drain_run_count", runs, 5);
    chk("drain_run_low", {31'h0, run}, 32'h0);
    drive(2'b01, 2'b00, 2'b00, 5'd1, 5'd0, 5'd0, 5'd0);
    step();
    step();
    chk("idle_ignores_commit", {31'h0, run}, 32'h0);
    chk("idle_no_overflow", {31'h0, overflow}, 32'h0);
    idle();

    // Overflow burst: 10 cycles of 2 commits into an 8-deep FIFO
    enable = 1'b1;
    step();
    chk("mrst_again", {31'h0, mon_reset}, 32'h1);
    step();
    runs = 0;
    breaks = 0;
    have_prev = 1'b0;
    prev_seq = 2'd0;
    for (int k = 0; k < 22; k++) begin
      if (k < 10) drive(2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
      else idle();
      step();
      if (run) begin
        runs++;
        if (have_prev && (symbols[7:6] != prev_seq + 2'd1)) breaks++;
        prev_seq = symbols[7:6];
        have_prev = 1'b1;
      end
      if (k == 7) chk("burst_no_drop_until_full", {31'h0, overflow}, 32'h0);
      if (k == 8) begin
        chk("burst_overflow", {31'h0, overflow}, 32'h1);
        chk("burst_drop1", {16'h0, drop_cnt}, 32'd1);
      end
    end
    chk("burst_drop_total", {16'h0, drop_cnt}, 32'd2);
    chk("burst_symbols_out", runs, 18);
    chk("burst_seq_contiguous", breaks, 0);
    chk("overflow_sticky", {31'h0, overflow}, 32'h1);

    // Asynchronous reset with FIFO non-empty
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b00, 2'b00, 5'd2, 5'd2, 5'd0, 5'd0);
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    chk("areset_symbols", {24'h0, symbols}, 32'h0);
    chk("areset_run", {31'h0, run}, 32'h0);
    chk("areset_overflow", {31'h0, overflow}, 32'h0);
    chk("areset_drop_cnt", {16'h0, drop_cnt}, 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_reset_mrst", {31'h0, mon_reset}, 32'h1);
    chk("post_reset_no_run0", {31'h0, run}, 32'h0);
    step();
    chk("post_reset_no_run1", {31'h0, run}, 32'h0);

    // Same-cycle load-use pair from a fresh start
    drive(2'b11, 2'b01, 2'b00, 5'd5, 5'd6, 5'd0, 5'd5);
    step();
    idle();
    chk("pair_sym0", {23'h0, run, symbols}, {23'h0, 1'b1, 8'h11});
    step();
    chk("pair_sym1", {23'h0, run, symbols}, {23'h0, 1'b1, 8'h4A});

    // Back-to-back single commits: seq continues 2,3,0,1,2
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
      step();
      chk($sformatf("wrap%0d", i), {23'h0, run, symbols}, {23'h0, 1'b1, wrap_exp[i]});
    end
    idle();
    step();
    chk("empty_hold", {23'h0, run, symbols}, {23'h0, 1'b0, 8'h80});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
